// File: rtl/gmii_mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : gmii_mac_tx
// Brief    : GMII transmit framer - preamble/SFD, payload, optional zero pad,
//            CRC-32 FCS, inter-frame gap, underrun signalling on txer.
//            Optional macro: GMII_TX_PAD_EN (pad payloads shorter than 60).
// Revision : 1.0 - initial release
// ============================================================================
module gmii_mac_tx #(
    parameter logic [7:0] SFD       = 8'hD5,
    parameter int         IFG_BYTES = 12
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] txd,
    output logic       txen,
    output logic       txer,
    output logic       gtx_clk,
    output logic       busy
);

    // Each state names what is driven onto the pins at the next rising edge.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
`ifdef GMII_TX_PAD_EN
        ST_PAD  = 3'd4,
`endif
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6,
        ST_DROP = 3'd7
    } state_t;

    localparam logic [7:0]  c_ifg_last = 8'(IFG_BYTES - 1);
`ifdef GMII_TX_PAD_EN
    localparam logic [10:0] c_min_frame = 11'd60;
`endif

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [10:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_txd;
    logic        r_txen;
    logic        r_txer;
    logic        r_s_ready;
    logic        r_busy;
    logic [10:0] w_byte_cnt_nxt;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_byte_cnt_nxt = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_byte_cnt <= 11'd0;
            r_crc      <= 32'hFFFFFFFF;
            r_txd      <= 8'h00;
            r_txen     <= 1'b0;
            r_txer     <= 1'b0;
            r_s_ready  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd     <= 8'h00;
                    r_txen    <= 1'b0;
                    r_txer    <= 1'b0;
                    r_s_ready <= 1'b0;
                    if (s_valid) begin
                        r_state    <= ST_PRE;
                        r_cnt      <= 8'd0;
                        r_byte_cnt <= 11'd0;
                        r_crc      <= 32'hFFFFFFFF;
                        r_busy     <= 1'b1;
                    end
                end
                ST_PRE: begin
                    r_txd  <= 8'h55;
                    r_txen <= 1'b1;
                    if (r_cnt == 8'd6) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_SFD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SFD: begin
                    r_txd     <= SFD;
                    r_txen    <= 1'b1;
                    r_s_ready <= 1'b1;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    // s_ready is always high here, so s_valid alone means accept.
                    if (s_valid) begin
                        r_txd      <= s_data;
                        r_crc      <= crc_byte(r_crc, s_data);
                        r_byte_cnt <= w_byte_cnt_nxt;
                        if (s_last) begin
                            r_s_ready <= 1'b0;
                            r_cnt     <= 8'd0;
`ifdef GMII_TX_PAD_EN
                            r_state   <= (w_byte_cnt_nxt < c_min_frame) ? ST_PAD : ST_FCS;
`else
                            r_state   <= ST_FCS;
`endif
                        end
                    end else begin
                        r_txd   <= 8'h00;
                        r_txer  <= 1'b1;
                        r_state <= ST_DROP;
                    end
                end
`ifdef GMII_TX_PAD_EN
                ST_PAD: begin
                    r_txd      <= 8'h00;
                    r_crc      <= crc_byte(r_crc, 8'h00);
                    r_byte_cnt <= w_byte_cnt_nxt;
                    if (w_byte_cnt_nxt == c_min_frame) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_FCS;
                    end
                end
`endif
                ST_FCS: begin
                    r_txd <= ~r_crc[7:0];
                    r_crc <= {8'h00, r_crc[31:8]};
                    if (r_cnt == 8'd3) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_IFG: begin
                    r_txd     <= 8'h00;
                    r_txen    <= 1'b0;
                    r_txer    <= 1'b0;
                    r_s_ready <= 1'b0;
                    if (r_cnt == c_ifg_last) begin
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DROP: begin
                    r_txd  <= 8'h00;
                    r_txen <= 1'b0;
                    r_txer <= 1'b0;
                    if (s_valid && s_last) begin
                        r_s_ready <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_IFG;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd     = r_txd;
    assign txen    = r_txen;
    assign txer    = r_txer;
    assign s_ready = r_s_ready;
    assign busy    = r_busy;
    assign gtx_clk = sys_clk;

endmodule
`default_nettype wire

// File: tb/tb_gmii_mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_mac_tx
// Brief    : Directed self-checking bench for gmii_mac_tx (default SFD and a
//            5D-SFD instance driven by the same source).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_mac_tx;

    localparam int c_ifg = 12;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       s_ready, txen, txer, gtx_clk, busy;
    logic [7:0] txd;
    logic       s_ready2, txen2, txer2, gtx_clk2, busy2;
    logic [7:0] txd2;

    gmii_mac_tx #(.SFD(8'hD5), .IFG_BYTES(c_ifg)) dut (
        .sys_clk(sys_clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .txd(txd), .txen(txen), .txer(txer),
        .gtx_clk(gtx_clk), .busy(busy));

    gmii_mac_tx #(.SFD(8'h5D), .IFG_BYTES(c_ifg)) dut2 (
        .sys_clk(sys_clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready2), .txd(txd2), .txen(txen2), .txer(txer2),
        .gtx_clk(gtx_clk2), .busy(busy2));

    always #4 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pay   [0:127];
    logic [7:0] fr    [0:127];
    logic [7:0] exp_b [0:255];
    int         exp_len = 0;

    logic [7:0] cap  [0:255];
    logic [7:0] cap2 [0:255];
    int  cap_n = 0, cap2_n = 0;
    logic prev_en = 1'b0, prev_en2 = 1'b0;
    int  cur_run = 0, last_run = 0, low_cnt = 0, last_gap = 0;
    int  txer_cnt = 0, zero_bad = 0, run_n = 0;
    int  run_hist [0:15];
    bit  gap_watch = 1'b0, rdy_gap_bad = 1'b0;

    // Frame capture: each rising txen restarts the byte buffer.
    always @(negedge sys_clk) begin
        if (txen) begin
            if (!prev_en) begin
                cap_n    = 0;
                cur_run  = 0;
                last_gap = low_cnt;
            end
            if (cap_n < 256) cap[cap_n] = txd;
            cap_n++;
            cur_run++;
            if (txer) txer_cnt++;
        end else begin
            if (prev_en) begin
                last_run = cur_run;
                if (run_n < 16) run_hist[run_n] = cur_run;
                run_n++;
                low_cnt = 0;
            end
            low_cnt++;
            if (txd != 8'h00) zero_bad++;
            if (gap_watch && s_ready) rdy_gap_bad = 1'b1;
        end
        prev_en = txen;
        if (txen2) begin
            if (!prev_en2) cap2_n = 0;
            if (cap2_n < 256) cap2[cap2_n] = txd2;
            cap2_n++;
        end
        prev_en2 = txen2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_fcs(input int m);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < m; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_exp(input int n, input logic [7:0] sfd);
        int m;
        logic [31:0] f;
        for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
        exp_b[7] = sfd;
        for (int i = 0; i < n; i++) fr[i] = pay[i];
        m = n;
`ifdef GMII_TX_PAD_EN
        while (m < 60) begin
            fr[m] = 8'h00;
            m++;
        end
`endif
        for (int i = 0; i < m; i++) exp_b[8 + i] = fr[i];
        f = ref_fcs(m);
        for (int b = 0; b < 4; b++) exp_b[8 + m + b] = f[8*b +: 8];
        exp_len = 8 + m + 4;
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, last_run, exp_len);
        for (int i = 0; i < exp_len; i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp_b[i]});
    endtask

    // Called just after a rising edge; returns just after the edge that took the last byte.
    task automatic send_frame(input int n, input int drop_at);
        int  i, guard;
        bit  acc, dropped;
        i = 0; guard = 0; dropped = 1'b0;
        s_valid = 1'b1; s_data = pay[0]; s_last = (n == 1);
        while (i < n && guard < 3000) begin
            @(negedge sys_clk);
            acc = s_valid && s_ready;
            @(posedge sys_clk);
            #1;
            guard++;
            if (acc) i++;
            if (!s_valid) s_valid = 1'b1;
            else if (i == drop_at && !dropped) begin
                s_valid = 1'b0;
                dropped = 1'b1;
            end
            s_data = pay[i];
            s_last = (i == n - 1);
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        chk("send_timeout", {31'h0, guard >= 3000}, 32'h0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int g = 0; g < 600; g++) begin
            @(negedge sys_clk);
            if (!busy) break;
            n++;
        end
        chk("idle_timeout", {31'h0, busy}, 32'h0);
        @(posedge sys_clk);
        #1;
    endtask

    int bc;

    initial begin
        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_txd", {24'h0, txd}, 32'h0);
        chk("rst_txen", {31'h0, txen}, 32'h0);
        chk("rst_txer", {31'h0, txer}, 32'h0);
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;

        // "123456789": known CRC-32 0xCBF43926
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        build_exp(9, 8'hD5);
        send_frame(9, -1);
        wait_idle(bc);
        cmp_frame("ascii9");
        chk("ascii9_busy_tail", bc, (exp_len - 8 - 9) + c_ifg);
`ifndef GMII_TX_PAD_EN
        chk("ascii9_txen_len", last_run, 21);
        chk("ascii9_fcs0", {24'h0, cap[17]}, 32'h26);
        chk("ascii9_fcs1", {24'h0, cap[18]}, 32'h39);
        chk("ascii9_fcs2", {24'h0, cap[19]}, 32'hF4);
        chk("ascii9_fcs3", {24'h0, cap[20]}, 32'hCB);
`endif

        // Short 14-byte frame (padded to 60 when padding is built in)
        for (int i = 0; i < 14; i++) pay[i] = 8'(i * 7 + 3);
        build_exp(14, 8'hD5);
        send_frame(14, -1);
        wait_idle(bc);
        cmp_frame("short14");
`ifdef GMII_TX_PAD_EN
        chk("short14_txen_len", last_run, 72);
`else
        chk("short14_txen_len", last_run, 26);
`endif

        // Back-to-back 64-byte frames with s_valid held high
        for (int i = 0; i < 64; i++) pay[i] = 8'(8'hC0 ^ i);
        build_exp(64, 8'hD5);
        run_n = 0; rdy_gap_bad = 1'b0; gap_watch = 1'b1;
        send_frame(64, -1);
        send_frame(64, -1);
        wait_idle(bc);
        gap_watch = 1'b0;
        chk("b2b_run0", run_hist[0], 76);
        chk("b2b_run1", run_hist[1], 76);
        chk("b2b_gap", last_gap, c_ifg + 1);
        chk("b2b_ready_in_gap", {31'h0, rdy_gap_bad}, 32'h0);
        cmp_frame("b2b_f2");

        // Underrun after payload byte 19
        txer_cnt = 0;
        send_frame(64, 20);
        wait_idle(bc);
        chk("urun_txer_cycles", txer_cnt, 1);
        chk("urun_txen_len", last_run, 29);
        chk("urun_txd_err", {24'h0, cap[28]}, 32'h0);
        chk("urun_last_good", {24'h0, cap[27]}, {24'h0, pay[19]});
        chk("urun_ifg", bc, c_ifg);

        // Reset pulse during preamble
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        s_valid = 1'b1; s_data = pay[0]; s_last = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        reset = 1'b1; s_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        chk("rpre_txen", {31'h0, txen}, 32'h0);
        chk("rpre_txer", {31'h0, txer}, 32'h0);
        chk("rpre_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rpre_busy", {31'h0, busy}, 32'h0);
        build_exp(9, 8'hD5);
        send_frame(9, -1);
        wait_idle(bc);
        cmp_frame("after_rpre");

        // Reset pulse during FCS of a non-padded frame
        for (int i = 0; i < 64; i++) pay[i] = 8'(8'h11 + i);
        send_frame(64, -1);
        @(posedge sys_clk);
        #1;
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        chk("rfcs_txen", {31'h0, txen}, 32'h0);
        chk("rfcs_txer", {31'h0, txer}, 32'h0);
        chk("rfcs_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rfcs_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        build_exp(9, 8'hD5);
        send_frame(9, -1);
        wait_idle(bc);
        cmp_frame("after_rfcs");

        // 60-byte frame on both SFD variants
        for (int i = 0; i < 60; i++) pay[i] = 8'(8'hA5 ^ (i * 3));
        build_exp(60, 8'hD5);
        send_frame(60, -1);
        wait_idle(bc);
        cmp_frame("sfd_d5");
        chk("sfd5d_len", cap2_n, 72);
        chk("sfd5d_byte8", {24'h0, cap2[7]}, 32'h5D);
        for (int b = 0; b < 4; b++)
            chk($sformatf("sfd5d_fcs%0d", b), {24'h0, cap2[68 + b]}, {24'h0, exp_b[68 + b]});

        chk("txd_zero_when_idle", zero_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gmii_mac_tx.md
# gmii_mac_tx

GMII transmit framer: takes a byte stream from the loopback/filter datapath through a valid/ready handshake and drives a GMII transmitter. It emits preamble and SFD, forwards the payload, optionally pads short frames, and appends the IEEE 802.3 FCS. It enforces the inter-frame gap and flags source underruns on `txer`. It is the transmit-side counterpart of `GMII_MAC_RX` and sits between the frame source and the PHY pins.

## Interface
- `SFD`, default 8'hD5: start-frame-delimiter byte, sent after the preamble.
- `IFG_BYTES`, default 12: idle cycles enforced after each frame, range 1..255.
- `sys_clk`  in  1  125 MHz transmit clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_data`  in  8  payload byte, destination MAC first.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  the current byte is the last payload byte.
- `s_ready`  out  1  byte accepted on an edge where `s_valid & s_ready`.
- `txd`  out  8  GMII transmit data, registered.
- `txen`  out  1  GMII transmit enable, registered.
- `txer`  out  1  GMII transmit error, registered.
- `gtx_clk`  out  1  forwarded `sys_clk`; pure assignment.
- `busy`  out  1  high from frame start to the end of the IFG.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP.
- IDLE: `s_ready`=0. If `s_valid`=1, go to PRE. The first byte stays held by the source and is not consumed.
- PRE: 7 cycles with `txd`=8'h55 and `txen`=1, then SFD.
- SFD: 1 cycle with `txd`=`SFD`. `s_ready`=1 in this cycle, so payload byte 0 is accepted here.
- DATA: `s_ready`=1 and one byte is accepted per cycle.
  - Each accepted byte appears on `txd` in the next cycle and is folded into the CRC.
  - On an accepted byte with `s_last`=1, go to PAD if the macro is enabled and the byte count is below 60; otherwise go to FCS.
- Underrun: `s_valid`=0 in any DATA cycle.
  - The next cycle drives `txen`=1, `txer`=1, `txd`=0.
  - Then go to DROP.
- DROP: `txen`=0 and `s_ready`=1. Bytes are discarded through the one with `s_last`=1, then go to IFG.
- PAD: `s_ready`=0. Drive 8'h00 bytes, included in the CRC, until the count reaches 60.
- FCS: 4 cycles carrying ~CRC, least-significant byte first.
  - CRC-32 uses reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - It covers the payload plus padding; preamble and SFD are excluded.
- IFG: `txen`=0 and `s_ready`=0 for `IFG_BYTES` cycles, then IDLE. `s_valid` is ignored during IFG.
- Byte counter: 11 bits, saturating at 2047. Frames longer than this are sent in full; the counter is used only for padding.
- `txd` is 8'h00 whenever `txen`=0.

## Timing
- Reset values: `txd`=0, `txen`=0, `txer`=0, `s_ready`=0, `busy`=0, state IDLE, CRC=0xFFFFFFFF, counters 0.
- Let `s_valid` be sampled in IDLE at edge k.
  - `txen` rises after edge k+1.
  - Preamble occupies cycles k+1..k+7; SFD is in cycle k+8.
  - Payload byte 0 appears in cycle k+9.
- `txen` stays high for 8 + max(N,60) + 4 cycles with padding, or 8 + N + 4 without, where N is the payload byte count. There are no gaps.
- After `txen` falls, at least `IFG_BYTES` cycles pass before it rises again. IDLE adds one further cycle.
- `busy` goes high with PRE and low on entry to IDLE.
- Reset asserted mid-frame: all outputs take their reset values at the next edge. No IFG is inserted and the partial frame is abandoned.
- Single-byte frame (`s_last` on byte 0): legal and padded as above.

## Configuration
- `GMII_TX_PAD_EN` defined: payloads shorter than 60 bytes are zero-padded to 60 before the FCS.
- Not defined: the PAD state is not compiled. FCS immediately follows the last payload byte, for any N ≥ 1.

## Test plan
- Macro off, payload ASCII "123456789" (9 bytes) → 7×55, D5, 31..39, then FCS 26 39 F4 CB; `txen` high for exactly 21 cycles.
- Macro on, 14-byte payload → 46 zero pad bytes after the payload, FCS matching a software CRC-32 over 60 bytes, `txen` high for 72 cycles.
- Two back-to-back 64-byte frames with `s_valid` held high → exactly 12 `txen`-low cycles plus 1 IDLE cycle between them; `s_ready` low throughout the gap.
- `s_valid` dropped at payload byte 20 → one cycle of `txen`=1, `txer`=1, then `txen`=0. Remaining bytes through `s_last` are accepted and discarded, followed by a 12-cycle IFG.
- `reset` pulsed for one cycle during PRE and again during FCS → `txen`, `txer`, `s_ready`, `busy` all 0 at the next edge. The next frame starts with a full preamble.
- `SFD`=8'h5D override, 60-byte frame → byte 8 on `txd` is 5D and the FCS is unchanged versus the D5 case.
